// File: rtl/operand_capture_stage_if.sv
// Decode-to-execute operand bus: register-file read ports, write-back port,
// pipeline control, and the registered operands handed to the execute stage.
interface operand_capture_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              ValidIn;
  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              WriteReg;
  logic [ADDR_W-1:0] DstReg;
  logic [DATA_W-1:0] DstData;
  logic              Stall;
  logic              Flush;
  logic              ValidOut;
  logic [DATA_W-1:0] Op1;
  logic [DATA_W-1:0] Op2;
  logic [ADDR_W-1:0] SrcReg1Q;
  logic [ADDR_W-1:0] SrcReg2Q;

  modport master (
    output ValidIn, SrcReg1, SrcReg2, ReadData1, ReadData2,
    output WriteReg, DstReg, DstData, Stall, Flush,
    input  ValidOut, Op1, Op2, SrcReg1Q, SrcReg2Q
  );

  modport slave (
    input  ValidIn, SrcReg1, SrcReg2, ReadData1, ReadData2,
    input  WriteReg, DstReg, DstData, Stall, Flush,
    output ValidOut, Op1, Op2, SrcReg1Q, SrcReg2Q
  );
endinterface

// File: rtl/operand_capture_stage.sv
// Decode-to-execute operand register with stall/flush. Define OPERAND_BYPASS_EN
// to enable write-back bypass on load and held-operand refresh during stall.
module operand_capture_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  operand_capture_stage_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_r;
  logic [DATA_W-1:0] op1_r;
  logic [DATA_W-1:0] op2_r;
  logic [ADDR_W-1:0] src1q_r;
  logic [ADDR_W-1:0] src2q_r;

  logic [0:0]        state_nx_s;
  logic [DATA_W-1:0] op1_nx_s;
  logic [DATA_W-1:0] op2_nx_s;
  logic [ADDR_W-1:0] src1q_nx_s;
  logic [ADDR_W-1:0] src2q_nx_s;

  // R0 never matches a write-back, so it can never be bypassed or refreshed.
  function automatic logic wb_hit(
    input logic              wr,
    input logic [ADDR_W-1:0] dst,
    input logic [ADDR_W-1:0] idx
  );
    wb_hit = wr && (dst == idx) && (idx != {ADDR_W{1'b0}});
  endfunction

  // Value presented by a read port after R0 masking and optional bypass.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rd
  );
    if (idx == {ADDR_W{1'b0}}) begin
      resolve = {DATA_W{1'b0}};
    end
`ifdef OPERAND_BYPASS_EN
    else if (wb_hit(bus.WriteReg, bus.DstReg, idx)) begin
      resolve = bus.DstData;
    end
`endif
    else begin
      resolve = rd;
    end
  endfunction

`ifndef OPERAND_BYPASS_EN
  logic unused_wb_s;
  assign unused_wb_s = ^{bus.WriteReg, bus.DstReg, bus.DstData};
`endif

  // Next-state selection with priority Flush > Stall > Load.
  always_comb begin
    state_nx_s = state_r;
    op1_nx_s   = op1_r;
    op2_nx_s   = op2_r;
    src1q_nx_s = src1q_r;
    src2q_nx_s = src2q_r;
    if (bus.Flush) begin
      state_nx_s = ST_EMPTY;
      op1_nx_s   = {DATA_W{1'b0}};
      op2_nx_s   = {DATA_W{1'b0}};
      src1q_nx_s = {ADDR_W{1'b0}};
      src2q_nx_s = {ADDR_W{1'b0}};
    end else if (bus.Stall) begin
`ifdef OPERAND_BYPASS_EN
      // Refresh is independent of validity so a long stall never goes stale.
      if (wb_hit(bus.WriteReg, bus.DstReg, src1q_r)) begin
        op1_nx_s = bus.DstData;
      end else begin
        op1_nx_s = op1_r;
      end
      if (wb_hit(bus.WriteReg, bus.DstReg, src2q_r)) begin
        op2_nx_s = bus.DstData;
      end else begin
        op2_nx_s = op2_r;
      end
`else
      op1_nx_s = op1_r;
      op2_nx_s = op2_r;
`endif
    end else begin
      state_nx_s = bus.ValidIn ? ST_FULL : ST_EMPTY;
      op1_nx_s   = resolve(bus.SrcReg1, bus.ReadData1);
      op2_nx_s   = resolve(bus.SrcReg2, bus.ReadData2);
      src1q_nx_s = bus.SrcReg1;
      src2q_nx_s = bus.SrcReg2;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      op1_r   <= {DATA_W{1'b0}};
      op2_r   <= {DATA_W{1'b0}};
      src1q_r <= {ADDR_W{1'b0}};
      src2q_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      op1_r   <= op1_nx_s;
      op2_r   <= op2_nx_s;
      src1q_r <= src1q_nx_s;
      src2q_r <= src2q_nx_s;
    end
  end

  assign bus.ValidOut = (state_r == ST_FULL);
  assign bus.Op1      = op1_r;
  assign bus.Op2      = op2_r;
  assign bus.SrcReg1Q = src1q_r;
  assign bus.SrcReg2Q = src2q_r;

endmodule

// File: tb/tb_operand_capture_stage.sv
// Randomized and directed bench for operand_capture_stage against a
// behavioural model of the stage's load/stall/flush rules.
module tb_operand_capture_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic chk_en;

  operand_capture_stage_if #(.DATA_W(16), .ADDR_W(4)) intf ();

  operand_capture_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the stage must currently hold.
  logic        m_valid;
  logic [15:0] m_op [2];
  logic [3:0]  m_src [2];

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [15:0] m_resolve(input logic [3:0] s, input logic [15:0] rd);
    if (s == 4'd0) return 16'h0000;
    if (BYP && intf.WriteReg && intf.DstReg == s) return intf.DstData;
    return rd;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {15'd0, intf.ValidOut}, {15'd0, m_valid});
      check("op1", intf.Op1, m_op[0]);
      check("op2", intf.Op2, m_op[1]);
      check("src1q", {12'd0, intf.SrcReg1Q}, {12'd0, m_src[0]});
      check("src2q", {12'd0, intf.SrcReg2Q}, {12'd0, m_src[1]});
    end
  end

  task automatic model_clear();
    m_valid = 1'b0;
    m_op[0] = 16'h0; m_op[1] = 16'h0;
    m_src[0] = 4'h0; m_src[1] = 4'h0;
  endtask

  // One clock: compute the expected next contents from the current inputs.
  task automatic step();
    logic        nv;
    logic [15:0] nop [2];
    logic [3:0]  ns [2];
    logic [3:0]  rs [2];
    logic [15:0] rd [2];
    rs[0] = intf.SrcReg1;   rs[1] = intf.SrcReg2;
    rd[0] = intf.ReadData1; rd[1] = intf.ReadData2;
    nv = m_valid;
    for (int p = 0; p < 2; p++) begin
      nop[p] = m_op[p];
      ns[p]  = m_src[p];
      if (intf.Flush) begin
        nv = 1'b0; nop[p] = 16'h0; ns[p] = 4'h0;
      end else if (intf.Stall) begin
        if (BYP && intf.WriteReg && intf.DstReg != 4'd0 && intf.DstReg == m_src[p])
          nop[p] = intf.DstData;
      end else begin
        nv = intf.ValidIn;
        nop[p] = m_resolve(rs[p], rd[p]);
        ns[p] = rs[p];
      end
    end
    @(posedge clk);
    m_valid = nv;
    m_op[0] = nop[0]; m_op[1] = nop[1];
    m_src[0] = ns[0]; m_src[1] = ns[1];
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [15:0] d1, input logic [15:0] d2,
                       input logic wr, input logic [3:0] dst, input logic [15:0] dd,
                       input logic st, input logic fl);
    intf.ValidIn = v; intf.SrcReg1 = s1; intf.SrcReg2 = s2;
    intf.ReadData1 = d1; intf.ReadData2 = d2;
    intf.WriteReg = wr; intf.DstReg = dst; intf.DstData = dd;
    intf.Stall = st; intf.Flush = fl;
  endtask

  initial begin
    errors = 0; checks = 0; chk_en = 1'b0;
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    model_clear();
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    #0;

    // Plain load
    drive(1'b1, 4'd3, 4'd5, 16'h00AA, 16'h0F0F, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step();
    check("load_valid", {15'd0, intf.ValidOut}, 16'd1);
    check("load_op1", intf.Op1, 16'h00AA);
    check("load_op2", intf.Op2, 16'h0F0F);
    check("load_src1q", {12'd0, intf.SrcReg1Q}, 16'd3);
    check("load_src2q", {12'd0, intf.SrcReg2Q}, 16'd5);

    // Bypass onto both ports
    drive(1'b1, 4'd7, 4'd7, 16'h1111, 16'h1111, 1'b1, 4'd7, 16'hBEEF, 1'b0, 1'b0);
    step();
    check("byp_op1", intf.Op1, BYP ? 16'hBEEF : 16'h1111);
    check("byp_op2", intf.Op2, BYP ? 16'hBEEF : 16'h1111);

    // R0 reads zero and is never bypassed
    drive(1'b1, 4'd0, 4'd2, 16'hFFFF, 16'h2222, 1'b1, 4'd0, 16'h5555, 1'b0, 1'b0);
    step();
    check("r0_op1", intf.Op1, 16'h0000);
    check("r0_op2", intf.Op2, 16'h2222);

    // Stall refresh
    drive(1'b1, 4'd1, 4'd4, 16'h0033, 16'h0001, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd9, 4'd9, 16'h9999, 16'h9999, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd9, 4'd9, 16'h9999, 16'h9999, 1'b1, 4'd4, 16'h8000, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd9, 4'd9, 16'h9999, 16'h9999, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    step();
    check("stall_valid", {15'd0, intf.ValidOut}, 16'd1);
    check("stall_op2", intf.Op2, BYP ? 16'h8000 : 16'h0001);
    check("stall_op1", intf.Op1, 16'h0033);
    check("stall_src2q", {12'd0, intf.SrcReg2Q}, 16'd4);

    // Flush over stall, then resume
    drive(1'b1, 4'd6, 4'd6, 16'h6666, 16'h6666, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
    step();
    check("flush_valid", {15'd0, intf.ValidOut}, 16'd0);
    check("flush_op1", intf.Op1, 16'h0000);
    check("flush_src1q", {12'd0, intf.SrcReg1Q}, 16'd0);
    drive(1'b1, 4'd8, 4'd9, 16'h0808, 16'h0909, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step();
    check("resume_valid", {15'd0, intf.ValidOut}, 16'd1);
    check("resume_op2", intf.Op2, 16'h0909);

    // Asynchronous reset between edges
    drive(1'b1, 4'd2, 4'd3, 16'h1234, 16'h4321, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    step();
    check("pre_rst_op1", intf.Op1, 16'h1234);
    #1 rst = 1'b1;
    model_clear();
    #1;
    check("rst_valid", {15'd0, intf.ValidOut}, 16'd0);
    check("rst_op1", intf.Op1, 16'h0000);
    check("rst_op2", intf.Op2, 16'h0000);
    @(posedge clk); #3 rst = 1'b0;

    // Randomized traffic with a narrow register range to force collisions
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
            16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 16'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_capture_stage.md
Name: operand_capture_stage

Overview:
- Decode-to-execute pipeline register that samples the two 16-bit register-file read ports each cycle and presents registered operands to the ALU.
- Supplies write-back bypass, because the register file does not forward a same-cycle write onto its read bitlines.
- Supports pipeline stall (hold) and flush (bubble insertion).
- Sits directly downstream of the register file read bitlines, upstream of the execute stage.

Parameters:
- DATA_W, 16, operand width; equals register width.
- ADDR_W, 4, register index width; 16 registers.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- ValidIn  input  1  decode stage presents a valid instruction this cycle
- SrcReg1  input  ADDR_W  index driven on read port 1
- SrcReg2  input  ADDR_W  index driven on read port 2
- ReadData1  input  DATA_W  value resolved on read bitline 1
- ReadData2  input  DATA_W  value resolved on read bitline 2
- WriteReg  input  1  write-back enable this cycle
- DstReg  input  ADDR_W  write-back register index
- DstData  input  DATA_W  write-back data
- Stall  input  1  hold current contents
- Flush  input  1  replace contents with bubble
- ValidOut  output  1  registered instruction valid
- Op1  output  DATA_W  registered operand 1
- Op2  output  DATA_W  registered operand 2
- SrcReg1Q  output  ADDR_W  registered index of operand 1
- SrcReg2Q  output  ADDR_W  registered index of operand 2

Behaviour:
- One clock (clk); reset is asynchronous, active-high (rst). All outputs are registers.
- Reset: ValidOut=0, Op1=Op2=0, SrcReg1Q=SrcReg2Q=0. Reset asserted mid-operation clears immediately, without waiting for a clock edge.
- Latency: 1 cycle from inputs to outputs. No combinational path from inputs to outputs.
- Per-edge priority: rst > Flush > Stall > Load.
- Two effective states, EMPTY (ValidOut=0) and FULL (ValidOut=1).
- Load (Flush=0, Stall=0):
  - ValidOut <= ValidIn.
  - SrcRegNQ <= SrcRegN.
  - OpN <= resolved value for port N.
- Resolved value for port N:
  - SrcRegN==0: 0. R0 always reads zero and is never bypassed.
  - Else if WriteReg and DstReg==SrcRegN and DstReg!=0: DstData (same-cycle bypass).
  - Else: ReadDataN.
  - Both ports resolve independently. If both name DstReg, both take DstData.
- Load with ValidIn=0: operands and indices are still captured, but ValidOut=0. The execute stage ignores data when ValidOut=0.
- Flush (takes precedence even with Stall=1): ValidOut <= 0, Op1/Op2 <= 0, SrcRegNQ <= 0.
- Stall (Flush=0): ValidOut and SrcRegNQ hold.
  - OpN holds, except held-operand refresh: if WriteReg and DstReg==SrcRegNQ and SrcRegNQ!=0, then OpN <= DstData.
  - Refresh occurs regardless of ValidOut.
  - A long stall therefore never presents a stale operand.
- WriteReg with DstReg==0: never bypassed or refreshed; R0 stays zero.
- Simultaneous Stall and Flush: Flush wins; the result is a bubble.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined: same-cycle bypass and held-operand refresh behave as above.
- Undefined: OpN takes ReadDataN on load (still zeroed when SrcRegN==0), and OpN simply holds during stall.
  - WriteReg, DstReg and DstData are unused.
  - The hazard unit must stall one extra cycle on write/read collisions.

Test Plan:
- Reset: assert rst asynchronously between edges with ValidOut=1, Op1=0x1234 -> ValidOut=0, Op1=Op2=0 before the next edge.
- Plain load: ValidIn=1, SrcReg1=3, SrcReg2=5, ReadData1=0x00AA, ReadData2=0x0F0F, WriteReg=0 -> next cycle ValidOut=1, Op1=0x00AA, Op2=0x0F0F, SrcReg1Q=3, SrcReg2Q=5.
- Bypass: SrcReg1=SrcReg2=7, ReadData1/2=0x1111, WriteReg=1, DstReg=7, DstData=0xBEEF -> Op1=Op2=0xBEEF.
  - Without OPERAND_BYPASS_EN -> Op1=Op2=0x1111.
- R0: SrcReg1=0, ReadData1=0xFFFF, WriteReg=1, DstReg=0, DstData=0x5555 -> Op1=0x0000.
- Stall refresh: load SrcReg2=4, Op2=0x0001; hold Stall=1 for 3 cycles; in cycle 2 drive WriteReg=1, DstReg=4, DstData=0x8000 -> ValidOut stays 1, Op2=0x8000 from the following edge, SrcReg2Q=4.
- Flush over stall: FULL state, Stall=1 and Flush=1 together -> next cycle ValidOut=0, Op1=Op2=0, SrcReg1Q=SrcReg2Q=0. Next load with Stall=0 resumes normally.
